// File: rtl/v_mask_gen_if.sv
// Request/stream interface of the mask-stream generator.
// The requester (master) drives the request fields and observes in_ready and the beat outputs.
// The generator (slave) consumes requests and drives the mask beats.
interface v_mask_gen_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
);
    logic                   in_valid;
    logic [COUNT_WIDTH-1:0] in_vl;
    logic [COUNT_WIDTH-1:0] in_count;
    logic [ADDR_WIDTH-1:0]  in_addr;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  out_vec;
    logic [ADDR_WIDTH-1:0]  out_addr;
    logic                   out_valid;
    logic                   out_end;

    modport master (
        output in_valid,
        output in_vl,
        output in_count,
        output in_addr,
        input  in_ready,
        input  out_vec,
        input  out_addr,
        input  out_valid,
        input  out_end
    );

    modport slave (
        input  in_valid,
        input  in_vl,
        input  in_count,
        input  in_addr,
        output in_ready,
        output out_vec,
        output out_addr,
        output out_valid,
        output out_end
    );
endinterface

// File: rtl/v_mask_gen.sv
// Mask-stream generator: expands (vl, count) into a stream of DATA_WIDTH-bit
// prefix-mask words, one per cycle at consecutive addresses. The first
// min(count, vl) bits of the stream are 1; the rest up to vl are 0.
module v_mask_gen #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    v_mask_gen_if.slave   bus
);

    localparam int LOG2_DW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    // Word width and word width minus one at the widened (COUNT_WIDTH+1) precision,
    // so a maximum in_vl rounds up without overflowing.
    localparam logic [COUNT_WIDTH:0]   DW_EXT_C    = (COUNT_WIDTH+1)'(DATA_WIDTH);
    localparam logic [COUNT_WIDTH:0]   DW_M1_EXT_C = (COUNT_WIDTH+1)'(DATA_WIDTH - 1);
    localparam logic [COUNT_WIDTH-1:0] DW_C        = COUNT_WIDTH'(DATA_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO_C  = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE_C   = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ZERO_C = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE_C  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0]  VEC_ZERO_C  = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0]  VEC_ONES_C  = {DATA_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Mask word for a beat that still has `ones` leading ones to place.
    function automatic logic [DATA_WIDTH-1:0] f_mask_word(input logic [COUNT_WIDTH-1:0] ones);
        logic [DATA_WIDTH-1:0] word;
        if ({1'b0, ones} >= DW_EXT_C) begin
            word = VEC_ONES_C;
        end else begin
            word = ~(VEC_ONES_C << ones[LOG2_DW-1:0]);
        end
        return word;
    endfunction

    // Ones still to place after one beat has consumed up to DATA_WIDTH of them.
    function automatic logic [COUNT_WIDTH-1:0] f_ones_after(input logic [COUNT_WIDTH-1:0] ones);
        logic [COUNT_WIDTH-1:0] rem;
        if ({1'b0, ones} >= DW_EXT_C) begin
            rem = ones - DW_C;
        end else begin
            rem = CNT_ZERO_C;
        end
        return rem;
    endfunction

    // State and stream bookkeeping. r_beats_left counts beats still to emit
    // after the one currently on the outputs.
    state_t                 r_state;
    logic [COUNT_WIDTH-1:0] r_beats_left;
    logic [COUNT_WIDTH-1:0] r_ones_rem;
    logic [ADDR_WIDTH-1:0]  r_next_addr;
    logic [DATA_WIDTH-1:0]  r_out_vec;
    logic [ADDR_WIDTH-1:0]  r_out_addr;
    logic                   r_out_valid;
    logic                   r_out_end;

    state_t                 w_state_nxt;
    logic [COUNT_WIDTH-1:0] w_beats_left_nxt;
    logic [COUNT_WIDTH-1:0] w_ones_rem_nxt;
    logic [ADDR_WIDTH-1:0]  w_next_addr_nxt;
    logic [DATA_WIDTH-1:0]  w_out_vec_nxt;
    logic [ADDR_WIDTH-1:0]  w_out_addr_nxt;
    logic                   w_out_valid_nxt;
    logic                   w_out_end_nxt;

    logic                   w_ready;
    logic                   w_accept;
    logic [COUNT_WIDTH:0]   w_vl_round;
    logic [COUNT_WIDTH:0]   w_req_beats_ext;
    logic [COUNT_WIDTH-1:0] w_req_beats;
    logic [COUNT_WIDTH-1:0] w_req_ones;

    assign w_ready  = (r_state == ST_IDLE);
    assign w_accept = bus.in_valid & w_ready;

    // ceil(vl / DATA_WIDTH) computed one bit wider than the count so vl at
    // its maximum still rounds up correctly.
    assign w_vl_round      = {1'b0, bus.in_vl} + DW_M1_EXT_C;
    assign w_req_beats_ext = w_vl_round >> LOG2_DW;
    assign w_req_beats     = w_req_beats_ext[COUNT_WIDTH-1:0];

    // Clamp the count to vl so tail bits past vl are never set.
    assign w_req_ones = (bus.in_count > bus.in_vl) ? bus.in_vl : bus.in_count;

    // Next-state and next-beat logic; outputs default to zero so an idle cycle
    // always presents a clean, all-zero beat.
    always_comb begin
        w_state_nxt      = r_state;
        w_beats_left_nxt = r_beats_left;
        w_ones_rem_nxt   = r_ones_rem;
        w_next_addr_nxt  = r_next_addr;
        w_out_vec_nxt    = VEC_ZERO_C;
        w_out_addr_nxt   = ADDR_ZERO_C;
        w_out_valid_nxt  = 1'b0;
        w_out_end_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept && (bus.in_vl != CNT_ZERO_C)) begin
                    // First beat is driven straight from the request.
                    w_state_nxt      = ST_EMIT;
                    w_out_valid_nxt  = 1'b1;
                    w_out_vec_nxt    = f_mask_word(w_req_ones);
                    w_out_addr_nxt   = bus.in_addr;
                    w_out_end_nxt    = (w_req_beats == CNT_ONE_C);
                    w_beats_left_nxt = w_req_beats - CNT_ONE_C;
                    w_ones_rem_nxt   = f_ones_after(w_req_ones);
                    w_next_addr_nxt  = bus.in_addr + ADDR_ONE_C;
                end else begin
                    // Nothing accepted, or an empty request that is simply consumed.
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_EMIT: begin
                if (r_beats_left == CNT_ZERO_C) begin
                    // The beat on the outputs was the last one.
                    w_state_nxt      = ST_IDLE;
                    w_beats_left_nxt = CNT_ZERO_C;
                    w_ones_rem_nxt   = CNT_ZERO_C;
                    w_next_addr_nxt  = ADDR_ZERO_C;
                end else begin
                    w_state_nxt      = ST_EMIT;
                    w_out_valid_nxt  = 1'b1;
                    w_out_vec_nxt    = f_mask_word(r_ones_rem);
                    w_out_addr_nxt   = r_next_addr;
                    w_out_end_nxt    = (r_beats_left == CNT_ONE_C);
                    w_beats_left_nxt = r_beats_left - CNT_ONE_C;
                    w_ones_rem_nxt   = f_ones_after(r_ones_rem);
                    w_next_addr_nxt  = r_next_addr + ADDR_ONE_C;
                end
            end

            default: begin
                w_state_nxt      = ST_IDLE;
                w_beats_left_nxt = CNT_ZERO_C;
                w_ones_rem_nxt   = CNT_ZERO_C;
                w_next_addr_nxt  = ADDR_ZERO_C;
            end
        endcase
    end

    // State register and registered beat outputs; reset aborts any stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_beats_left <= CNT_ZERO_C;
            r_ones_rem   <= CNT_ZERO_C;
            r_next_addr  <= ADDR_ZERO_C;
            r_out_vec    <= VEC_ZERO_C;
            r_out_addr   <= ADDR_ZERO_C;
            r_out_valid  <= 1'b0;
            r_out_end    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_beats_left <= w_beats_left_nxt;
            r_ones_rem   <= w_ones_rem_nxt;
            r_next_addr  <= w_next_addr_nxt;
            r_out_vec    <= w_out_vec_nxt;
            r_out_addr   <= w_out_addr_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_end    <= w_out_end_nxt;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_vec   = r_out_vec;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_valid = r_out_valid;
    assign bus.out_end   = r_out_end;

endmodule
